// File: rtl/ixc_assign_pkg.sv
// Shared types and helpers for the ixc_assign register pipeline.
// Optional feature macro: IXC_ASSIGN_PAR_EN (per-32-bit-slice even parity).
package ixc_assign_pkg;

    // Data bits covered by one parity bit.
    localparam int PAR_SLICE = 32;

    // Per-stage flow-control view: does the stage hold a beat, may it advance.
    typedef struct packed {
        logic valid;
        logic ready;
    } stage_ctl_t;

    // Number of parity slices for a given data width (last slice may be short).
    function automatic int par_slices(input int width);
        return (width + PAR_SLICE - 1) / PAR_SLICE;
    endfunction

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ixc_assign_stage.sv
// One register stage of the ixc_assign pipeline: data, valid and (when
// IXC_ASSIGN_PAR_EN is defined) the parity bits that travel with the data.
module ixc_assign_stage
    import ixc_assign_pkg::*;
#(
    parameter int               WIDTH     = 132,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef IXC_ASSIGN_PAR_EN
    ,
    parameter int               PW        = par_slices(WIDTH)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             ready_i,   // readiness of the downstream stage / sink
`ifdef IXC_ASSIGN_PAR_EN
    input  logic [PW-1:0]    par_i,
    output logic [PW-1:0]    par_o,
`endif
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             valid_d;
    logic             data_en;
    stage_ctl_t       ctl;
`ifdef IXC_ASSIGN_PAR_EN
    logic [PW-1:0]    par_q;
`endif

    // Stage may take a new beat when it is empty or its beat leaves this cycle.
    always_comb begin
        ctl.valid = valid_q;
        ctl.ready = !valid_q || ready_i;
        valid_d   = ctl.ready ? valid_i : valid_q;
        // Data only moves for a real beat so an idle stage keeps its last value.
        data_en   = ctl.ready && valid_i;
    end

    // Stage registers: async reset, synchronous flush to the reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
`ifdef IXC_ASSIGN_PAR_EN
            par_q   <= '0;
`endif
        end else if (flush) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
`ifdef IXC_ASSIGN_PAR_EN
            par_q   <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            if (data_en) begin
                data_q <= data_i;
`ifdef IXC_ASSIGN_PAR_EN
                par_q  <= par_i;
`endif
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = ctl.valid;
`ifdef IXC_ASSIGN_PAR_EN
    assign par_o   = par_q;
`endif

endmodule

// File: rtl/ixc_assign_pipe.sv
// ixc_assign_pipe: WIDTH-bit, DEPTH-stage registered transfer L <= R with
// valid/ready flow control, synchronous flush and stage occupancy count.
// Optional feature macro: IXC_ASSIGN_PAR_EN adds per-32-bit even parity carried
// through the stages, checked at the output, reported on sticky par_err.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. valid never depends on ready of the same
// interface; a valid beat is held stable until accepted. R_ready may depend
// combinationally on L_ready (the ready chain has no bubble); L_valid is a
// register output.
module ixc_assign_pipe
    import ixc_assign_pkg::*;
#(
    parameter int               WIDTH     = 132,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         R,
    input  logic                     R_valid,
    output logic                     R_ready,
    output logic [WIDTH-1:0]         L,
    output logic                     L_valid,
    input  logic                     L_ready,
    output logic [occ_w(DEPTH)-1:0]  occ
`ifdef IXC_ASSIGN_PAR_EN
    ,
    output logic                     par_err
`endif
);

    localparam int OCC_W = occ_w(DEPTH);
`ifdef IXC_ASSIGN_PAR_EN
    localparam int NP    = par_slices(WIDTH);
`endif

    // Index k is the input of stage k; index DEPTH is the last stage's output.
    logic [WIDTH-1:0] d_chain [DEPTH+1];
    logic [DEPTH:0]   v_chain;
    logic [DEPTH-1:0] nxt_rdy;   // nxt_rdy[k]: stage k+1 (or the sink) accepts
    logic [OCC_W-1:0] occ_c;

`ifdef IXC_ASSIGN_PAR_EN
    logic [NP-1:0]    p_chain [DEPTH+1];
    logic             par_err_q;

    // Even parity per PAR_SLICE-bit slice: each bit is the XOR of its slice.
    function automatic logic [NP-1:0] calc_par(input logic [WIDTH-1:0] d);
        logic [NP-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            p[i / PAR_SLICE] = p[i / PAR_SLICE] ^ d[i];
        end
        return p;
    endfunction

    assign p_chain[0] = calc_par(R);
`endif

    assign d_chain[0] = R;
    assign v_chain[0] = R_valid;

    // Ready lookahead built from registered valids only, so no combinational
    // loop runs through the stages: a stage may advance if the sink is ready
    // or any stage after it is empty.
    always_comb begin
        logic acc;
        nxt_rdy = '0;
        acc     = L_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            nxt_rdy[k] = acc;
            acc        = acc || !v_chain[k+1];
        end
        R_ready = acc;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        ixc_assign_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
`ifdef IXC_ASSIGN_PAR_EN
            ,
            .PW        (NP)
`endif
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .data_i  (d_chain[k]),
            .valid_i (v_chain[k]),
            .ready_i (nxt_rdy[k]),
`ifdef IXC_ASSIGN_PAR_EN
            .par_i   (p_chain[k]),
            .par_o   (p_chain[k+1]),
`endif
            .data_o  (d_chain[k+1]),
            .valid_o (v_chain[k+1])
        );
    end

    // Occupancy is the number of stages currently holding a beat.
    always_comb begin
        occ_c = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            occ_c = occ_c + OCC_W'(v_chain[k]);
        end
    end

`ifdef IXC_ASSIGN_PAR_EN
    // Sticky parity error: set when the output beat disagrees with its
    // carried parity; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if (v_chain[DEPTH] && (calc_par(d_chain[DEPTH]) != p_chain[DEPTH])) begin
            par_err_q <= 1'b1;
        end
    end

    assign par_err = par_err_q;
`endif

    assign L       = d_chain[DEPTH];
    assign L_valid = v_chain[DEPTH];
    assign occ     = occ_c;

endmodule

// File: tb/tb_ixc_assign_pipe.sv
// Bench for ixc_assign_pipe. Three instances share clock/reset/flush:
// lane 0 WIDTH=132 DEPTH=2, lane 1 WIDTH=1 DEPTH=4, lane 2 WIDTH=132 DEPTH=1.
// The reference model is a FIFO queue per lane: beats accepted on R must leave
// on L in order, occ equals the number of beats inside the pipe, and R_ready is
// high exactly when the pipe has a free slot or the sink is taking a beat.
module tb_ixc_assign_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush;

    logic [131:0] r_d  [3];
    logic [131:0] l_d  [3];
    logic         rv   [3];
    logic         rr   [3];
    logic         lv   [3];
    logic         lr   [3];
    logic [2:0]   occ_v[3];

    logic [131:0] l0, l2;
    logic [0:0]   l1;
    logic [1:0]   occ0;
    logic [2:0]   occ1;
    logic [0:0]   occ2;
`ifdef IXC_ASSIGN_PAR_EN
    logic         perr0, perr1, perr2;
`endif

    int lw    [3] = '{132, 1, 132};
    int ldep  [3] = '{2, 4, 1};

    int errors = 0;
    int checks = 0;

    assign l_d[0]   = l0;
    assign l_d[1]   = {131'd0, l1};
    assign l_d[2]   = l2;
    assign occ_v[0] = {1'b0, occ0};
    assign occ_v[1] = occ1;
    assign occ_v[2] = {2'b00, occ2};

    ixc_assign_pipe #(.WIDTH(132), .DEPTH(2)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .R(r_d[0]), .R_valid(rv[0]), .R_ready(rr[0]),
        .L(l0), .L_valid(lv[0]), .L_ready(lr[0]), .occ(occ0)
`ifdef IXC_ASSIGN_PAR_EN
        , .par_err(perr0)
`endif
    );

    ixc_assign_pipe #(.WIDTH(1), .DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .R(r_d[1][0:0]), .R_valid(rv[1]), .R_ready(rr[1]),
        .L(l1), .L_valid(lv[1]), .L_ready(lr[1]), .occ(occ1)
`ifdef IXC_ASSIGN_PAR_EN
        , .par_err(perr1)
`endif
    );

    ixc_assign_pipe #(.WIDTH(132), .DEPTH(1)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .R(r_d[2]), .R_valid(rv[2]), .R_ready(rr[2]),
        .L(l2), .L_valid(lv[2]), .L_ready(lr[2]), .occ(occ2)
`ifdef IXC_ASSIGN_PAR_EN
        , .par_err(perr2)
`endif
    );

    // Expected beats in flight per lane, oldest at the front.
    logic [131:0] exp_q [3][$];

    function automatic logic [131:0] msk(input int w);
        logic [131:0] one;
        one = 132'd1;
        return (one << w) - one;
    endfunction

    function automatic logic [131:0] rand132();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[131:0];
    endfunction

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            rv[k]  = 1'b0;
            lr[k]  = 1'b0;
            r_d[k] = '0;
        end
    endtask

    // Push n beats into lane 0 with the sink stalled; each must be accepted.
    task automatic fill_lane0(input logic [131:0] b0, input logic [131:0] b1);
        logic [131:0] bs [2];
        bs[0] = b0;
        bs[1] = b1;
        lr[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rv[0]  = 1'b1;
            r_d[0] = bs[i];
            #1;
            checks++;
            if (rr[0] !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready beat=%0d got=%b want=1", i, rr[0]);
            end
        end
        @(negedge clk);
        rv[0] = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        flush = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (lv[k] !== 1'b0 || occ_v[k] !== 3'd0 || l_d[k] !== 132'd0) begin
                errors++;
                $display("FAIL reset_state lane=%0d got lv=%b occ=%0d L=%h want lv=0 occ=0 L=0",
                         k, lv[k], occ_v[k], l_d[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rr[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_rready lane=%0d got=%b want=1", k, rr[k]);
            end
        end
    endtask

    // Beats 0..9 back to back with the sink always ready: first beat at
    // cycle 2, then one per cycle.
    task automatic test_streaming();
        lr[0] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            rv[0]  = (c < 10);
            r_d[0] = 132'(c);
            #1;
            checks++;
            if (rr[0] !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready cycle=%0d got=%b want=1", c, rr[0]);
            end
            checks++;
            if (lv[0] !== ((c >= 2) && (c < 12))) begin
                errors++;
                $display("FAIL stream_valid cycle=%0d got=%b want=%b", c, lv[0], (c >= 2) && (c < 12));
            end else if (lv[0] && l_d[0] !== 132'(c - 2)) begin
                errors++;
                $display("FAIL stream_data cycle=%0d got=%h want=%h", c, l_d[0], 132'(c - 2));
            end
        end
        rv[0] = 1'b0;
        lr[0] = 1'b0;
    endtask

    // Sink stalled: only DEPTH=2 of 3 offered beats get in; release drains in order.
    task automatic test_backpressure();
        logic [131:0] beats [3];
        int accepted;
        beats[0] = 132'hA1;
        beats[1] = 132'hA2;
        beats[2] = 132'hA3;
        accepted = 0;
        lr[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rv[0]  = 1'b1;
            r_d[0] = beats[accepted];
            #1;
            checks++;
            if (rr[0] !== (c < 2)) begin
                errors++;
                $display("FAIL bp_ready cycle=%0d got=%b want=%b", c, rr[0], c < 2);
            end
            if (rr[0] === 1'b1) accepted++;
        end
        @(negedge clk);
        rv[0] = 1'b0;
        #1;
        checks++;
        if (accepted != 2 || occ_v[0] !== 3'd2 || lv[0] !== 1'b1 || l_d[0] !== beats[0] || rr[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got acc=%0d occ=%0d lv=%b L=%h rr=%b want acc=2 occ=2 lv=1 L=a1 rr=0",
                     accepted, occ_v[0], lv[0], l_d[0], rr[0]);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            lr[0] = 1'b1;
            #1;
            checks++;
            if (c < 2) begin
                if (lv[0] !== 1'b1 || l_d[0] !== beats[c]) begin
                    errors++;
                    $display("FAIL bp_drain idx=%0d got lv=%b L=%h want lv=1 L=%h", c, lv[0], l_d[0], beats[c]);
                end
            end else if (lv[0] !== 1'b0 || occ_v[0] !== 3'd0) begin
                errors++;
                $display("FAIL bp_empty got lv=%b occ=%0d want lv=0 occ=0", lv[0], occ_v[0]);
            end
        end
        lr[0] = 1'b0;
    endtask

    // Flush with two beats inside and a beat on R: all three must vanish.
    task automatic test_flush();
        fill_lane0(132'hB1, 132'hB2);
        #1;
        checks++;
        if (occ_v[0] !== 3'd2) begin
            errors++;
            $display("FAIL flush_pre_occ got=%0d want=2", occ_v[0]);
        end
        @(negedge clk);
        flush  = 1'b1;
        rv[0]  = 1'b1;
        r_d[0] = 132'hEE;
        @(negedge clk);
        flush = 1'b0;
        rv[0] = 1'b0;
        #1;
        checks++;
        if (occ_v[0] !== 3'd0 || lv[0] !== 1'b0 || l_d[0] !== 132'd0) begin
            errors++;
            $display("FAIL flush_clear got occ=%0d lv=%b L=%h want occ=0 lv=0 L=0", occ_v[0], lv[0], l_d[0]);
        end
        lr[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (lv[0] !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost cycle=%0d got lv=%b L=%h want lv=0", c, lv[0], l_d[0]);
            end
        end
        lr[0] = 1'b0;
    endtask

    // Reset mid-stream: in-flight beats drop at once, nothing emerges later.
    task automatic test_reset_midstream();
        fill_lane0(132'hC1, 132'hC2);
        #1;
        checks++;
        if (occ_v[0] !== 3'd2 || lv[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got occ=%0d lv=%b want occ=2 lv=1", occ_v[0], lv[0]);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (lv[0] !== 1'b0 || occ_v[0] !== 3'd0 || l_d[0] !== 132'd0) begin
            errors++;
            $display("FAIL rstmid_async got lv=%b occ=%0d L=%h want lv=0 occ=0 L=0", lv[0], occ_v[0], l_d[0]);
        end
        @(negedge clk);
        rst   = 1'b0;
        lr[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (lv[0] !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_ghost cycle=%0d got lv=%b L=%h want lv=0", c, lv[0], l_d[0]);
            end
        end
        lr[0] = 1'b0;
    endtask

    // Random valid/ready on all three lanes against the FIFO model.
    task automatic test_random();
        int delivered [3];
        int pushed    [3];
        for (int k = 0; k < 3; k++) begin
            exp_q[k].delete();
            delivered[k] = 0;
            pushed[k]    = 0;
        end
        for (int c = 0; c < 4400; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (c < 4000) begin
                    rv[k] = ($urandom_range(0, 3) != 0);
                    // Alternate light and heavy backpressure phases.
                    lr[k] = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                end else begin
                    rv[k] = 1'b0;
                    lr[k] = 1'b1;
                end
                r_d[k] = rand132() & msk(lw[k]);
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (occ_v[k] !== 3'(exp_q[k].size())) begin
                    errors++;
                    $display("FAIL rand_occ lane=%0d cycle=%0d got=%0d want=%0d", k, c, occ_v[k], exp_q[k].size());
                end
                checks++;
                if (rr[k] !== ((exp_q[k].size() < ldep[k]) || lr[k])) begin
                    errors++;
                    $display("FAIL rand_ready lane=%0d cycle=%0d got=%b want=%b", k, c, rr[k],
                             (exp_q[k].size() < ldep[k]) || lr[k]);
                end
                if (lv[k] === 1'b1 && lr[k]) begin
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        errors++;
                        $display("FAIL rand_spurious lane=%0d cycle=%0d got L=%h want no beat", k, c, l_d[k]);
                    end else begin
                        if (l_d[k] !== exp_q[k][0]) begin
                            errors++;
                            $display("FAIL rand_data lane=%0d cycle=%0d got=%h want=%h", k, c, l_d[k], exp_q[k][0]);
                        end
                        void'(exp_q[k].pop_front());
                        delivered[k]++;
                    end
                end
                if (rv[k] && rr[k] === 1'b1) begin
                    exp_q[k].push_back(r_d[k]);
                    pushed[k]++;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (exp_q[k].size() != 0 || delivered[k] != pushed[k] || pushed[k] < 500) begin
                errors++;
                $display("FAIL rand_drain lane=%0d got left=%0d out=%0d in=%0d want left=0 out=in>=500",
                         k, exp_q[k].size(), delivered[k], pushed[k]);
            end
        end
        idle_all();
    endtask

`ifdef IXC_ASSIGN_PAR_EN
    // Corrupt bit 40 of the last-stage data while it holds a beat.
    task automatic test_parity();
        fill_lane0(132'h5, 132'h6);
        #1;
        checks++;
        if (perr0 !== 1'b0) begin
            errors++;
            $display("FAIL par_clean got=%b want=0", perr0);
        end
        force dut0.g_stage[1].u_stage.data_q[40] = 1'b1;
        @(negedge clk);
        #1;
        release dut0.g_stage[1].u_stage.data_q[40];
        checks++;
        if (perr0 !== 1'b1) begin
            errors++;
            $display("FAIL par_detect got=%b want=1", perr0);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (perr0 !== 1'b1 || occ_v[0] !== 3'd0) begin
            errors++;
            $display("FAIL par_sticky got err=%b occ=%0d want err=1 occ=0", perr0, occ_v[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (perr0 !== 1'b0) begin
            errors++;
            $display("FAIL par_rst got=%b want=0", perr0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        idle_all();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
`ifdef IXC_ASSIGN_PAR_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
